// File: rtl/apb_intc_pkg.sv
// Shared constants for the APB interrupt controller: register offsets and
// CLAIM register field layout.
package apb_intc_pkg;

  localparam logic [3:0] OFF_PENDING = 4'h0;
  localparam logic [3:0] OFF_ENABLE  = 4'h4;
  localparam logic [3:0] OFF_MODE    = 4'h8;
  localparam logic [3:0] OFF_CLAIM   = 4'hC;

  localparam int CLAIM_VALID_BIT = 31;
  localparam int ID_W            = 5;

endpackage

// File: rtl/apb_intc_if.sv
// APB bus bundle used between a master and the interrupt controller.
// pdata is write data, prdata is read data; pstb carries byte write strobes.
interface apb_intc_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [3:0]            pstb;
  logic                  pready;
  logic                  perr;

  modport master (
    output paddr, pdata, psel, penable, pwrite, pstb,
    input  prdata, pready, perr
  );

  modport slave (
    input  paddr, pdata, psel, penable, pwrite, pstb,
    output prdata, pready, perr
  );
endinterface

// File: rtl/apb_intc_prio_enc.sv
// Lowest-index-first priority encoder: index 0 wins. valid_o flags any request.
module apb_intc_prio_enc
  import apb_intc_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic               valid_o,
  output logic [ID_W-1:0]    id_o
);

  always_comb begin
    valid_o = |req_i;
    id_o    = '0;
    // Scan downwards so the last hit, i.e. the lowest set index, is kept.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/apb_intc.sv
// APB interrupt controller: edge/level sources with enable, W1C pending, a
// claim register, and a registered CPU interrupt line with an unmaskable nmi.
module apb_intc
  import apb_intc_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_SRC    = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h20000000
) (
  input  logic               pclk_i,
  input  logic               presetn_i,
  apb_intc_if.slave          pbus,
  input  logic [NUM_SRC-1:0] irq_src_i,
  input  logic               nmi_i,
  output logic               cpu_interrupt_o
);

  logic [NUM_SRC-1:0]    pending_q, pending_d;
  logic [NUM_SRC-1:0]    enable_q, enable_d;
  logic [NUM_SRC-1:0]    mode_q, mode_d;
  logic [NUM_SRC-1:0]    src_q;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q;
  logic                  perr_q, perr_d;
  logic                  cpu_int_q;

  logic                  access, addr_ok, wr_ok, rd_ok;
  logic [3:0]            offset;
  logic [NUM_SRC-1:0]    wmask, wbits, set_edge, clr, claim_clr, claimable;
  logic                  claim_valid;
  logic [ID_W-1:0]       claim_id;
  logic                  unused_ok;

  assign access  = pbus.psel & pbus.penable & ~pready_q;
  assign addr_ok = (pbus.paddr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]) &&
                   (pbus.paddr[1:0] == 2'b00);
  assign offset  = pbus.paddr[3:0];
  assign wr_ok   = access & addr_ok & pbus.pwrite;
  assign rd_ok   = access & addr_ok & ~pbus.pwrite;

  // Register bits at or above NUM_SRC do not exist; their write data is dropped.
  assign unused_ok = ^{pbus.pdata, pbus.pstb};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_mask
    assign wmask[g] = pbus.pstb[g/8];
  end
  assign wbits = pbus.pdata[NUM_SRC-1:0] & wmask;

  assign claimable = pending_q & enable_q;

  apb_intc_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
    .req_i   (claimable),
    .valid_o (claim_valid),
    .id_o    (claim_id)
  );

  // Clears only ever land on edge-mode bits; a same-cycle rising edge still wins.
  assign claim_clr = (rd_ok && offset == OFF_CLAIM && claim_valid) ?
                     ((NUM_SRC'(1) << claim_id) & mode_q) : '0;
  assign clr       = (((wr_ok && offset == OFF_PENDING) ? wbits : '0) & mode_q) | claim_clr;
  assign set_edge  = irq_src_i & ~src_q;
  assign pending_d = (mode_q & (set_edge | (pending_q & ~clr))) | (~mode_q & irq_src_i);

  assign enable_d = (wr_ok && offset == OFF_ENABLE) ? ((enable_q & ~wmask) | wbits) : enable_q;
  assign mode_d   = (wr_ok && offset == OFF_MODE)   ? ((mode_q & ~wmask) | wbits)   : mode_q;

  always_comb begin
    prdata_d = '0;
    perr_d   = 1'b0;
    if (access) begin
      perr_d = ~addr_ok;
      if (rd_ok) begin
        case (offset)
          OFF_PENDING: prdata_d = DATA_WIDTH'(pending_q);
          OFF_ENABLE:  prdata_d = DATA_WIDTH'(enable_q);
          OFF_MODE:    prdata_d = DATA_WIDTH'(mode_q);
          OFF_CLAIM: begin
            prdata_d[CLAIM_VALID_BIT] = claim_valid;
            prdata_d[ID_W-1:0]        = claim_id;
          end
          default: prdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      pending_q <= '0;
      enable_q  <= '0;
      mode_q    <= '0;
      src_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      perr_q    <= 1'b0;
      cpu_int_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      mode_q    <= mode_d;
      src_q     <= irq_src_i;
      prdata_q  <= prdata_d;
      pready_q  <= access;
      perr_q    <= perr_d;
      cpu_int_q <= (|claimable) | nmi_i;
    end
  end

  assign pbus.prdata     = prdata_q;
  assign pbus.pready     = pready_q;
  assign pbus.perr       = perr_q;
  assign cpu_interrupt_o = cpu_int_q;

endmodule

// File: tb/tb_apb_intc.sv
// Self-checking bench for apb_intc: directed scenarios plus randomized traffic
// checked against a per-source behavioural model of pending/enable/mode.
module tb_apb_intc;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          NS   = 8;
  localparam logic [31:0] BASE = 32'h2000_0000;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [NS-1:0] irq_src;
  logic          nmi;
  logic          cpu_int;

  apb_intc_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_intc #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_SRC    (NS),
    .BASE_ADDR  (BASE)
  ) dut (
    .pclk_i          (clk),
    .presetn_i       (rst_n),
    .pbus            (bus),
    .irq_src_i       (irq_src),
    .nmi_i           (nmi),
    .cpu_interrupt_o (cpu_int)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state (current) and next values computed before each edge.
  bit m_pend[NS], m_en[NS], m_mode[NS], m_srcq[NS];
  bit n_pend[NS], n_en[NS], n_mode[NS], n_srcq[NS];
  bit m_cpu, n_cpu;

  bit          acc_now;
  bit          acc_wr;
  logic [31:0] acc_addr, acc_data;
  logic [3:0]  acc_strb;
  logic [31:0] exp_rdata;
  bit          exp_err;

  task automatic model_step();
    int   claim_id;
    bit   clr[NS];
    bit   wr_ok, rd_ok;
    logic [3:0] off;
    claim_id = -1;
    for (int i = NS - 1; i >= 0; i--) if (m_pend[i] && m_en[i]) claim_id = i;
    n_cpu = nmi || (claim_id >= 0);
    exp_rdata = '0;
    exp_err   = 1'b0;
    wr_ok = 1'b0;
    rd_ok = 1'b0;
    off   = acc_addr[3:0];
    for (int i = 0; i < NS; i++) clr[i] = 1'b0;
    if (acc_now) begin
      if ((acc_addr >> 4) == (BASE >> 4) && (acc_addr % 4) == 0) begin
        wr_ok = acc_wr;
        rd_ok = !acc_wr;
      end else begin
        exp_err = 1'b1;
      end
    end
    if (rd_ok) begin
      case (off)
        4'h0: for (int i = 0; i < NS; i++) exp_rdata[i] = m_pend[i];
        4'h4: for (int i = 0; i < NS; i++) exp_rdata[i] = m_en[i];
        4'h8: for (int i = 0; i < NS; i++) exp_rdata[i] = m_mode[i];
        4'hC: if (claim_id >= 0) begin
          exp_rdata = 32'h8000_0000 + 32'(claim_id);
          clr[claim_id] = m_mode[claim_id];
        end
        default: ;
      endcase
    end
    n_en   = m_en;
    n_mode = m_mode;
    for (int i = 0; i < NS; i++) begin
      if (wr_ok && acc_strb[i/8]) begin
        case (off)
          4'h0: if (acc_data[i] && m_mode[i]) clr[i] = 1'b1;
          4'h4: n_en[i]   = acc_data[i];
          4'h8: n_mode[i] = acc_data[i];
          default: ;
        endcase
      end
      if (m_mode[i]) n_pend[i] = (irq_src[i] && !m_srcq[i]) || (m_pend[i] && !clr[i]);
      else           n_pend[i] = irq_src[i];
      n_srcq[i] = irq_src[i];
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    m_pend = n_pend;
    m_en   = n_en;
    m_mode = n_mode;
    m_srcq = n_srcq;
    m_cpu  = n_cpu;
  endtask

  task automatic apb_begin(input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pdata   = data;
    bus.pstb    = strb;
    tick();
    bus.penable = 1'b1;
    acc_now  = 1'b1;
    acc_wr   = wr;
    acc_addr = addr;
    acc_data = data;
    acc_strb = strb;
  endtask

  task automatic apb_end(output logic rdy, output logic [31:0] rd, output logic er);
    tick();
    rdy = bus.pready;
    rd  = bus.prdata;
    er  = bus.perr;
    acc_now     = 1'b0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic rdy, er;
    logic [31:0] rd;
    apb_begin(1'b1, addr, data, strb);
    apb_end(rdy, rd, er);
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] rd);
    logic rdy, er;
    apb_begin(1'b0, addr, 32'h0, 4'h0);
    apb_end(rdy, rd, er);
  endtask

  task automatic apply_reset();
    rst_n       = 1'b0;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
    bus.paddr   = '0;
    bus.pdata   = '0;
    bus.pstb    = '0;
    irq_src     = '0;
    nmi         = 1'b0;
    acc_now     = 1'b0;
    acc_addr    = '0;
    for (int i = 0; i < NS; i++) begin
      m_pend[i] = 1'b0; m_en[i] = 1'b0; m_mode[i] = 1'b0; m_srcq[i] = 1'b0;
    end
    m_cpu = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic rdy, er;
    logic [31:0] rd;
    apply_reset();
    checks++;
    if (cpu_int !== 1'b0 || bus.pready !== 1'b0 || bus.perr !== 1'b0 || bus.prdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs actual cpu=%b rdy=%b err=%b rd=%h required all 0",
               cpu_int, bus.pready, bus.perr, bus.prdata);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      apb_begin(1'b0, BASE + 32'(4 * k), 32'h0, 4'h0);
      apb_end(rdy, rd, er);
      checks++;
      if (rdy !== 1'b1 || er !== 1'b0 || rd !== 32'h0 || cpu_int !== 1'b0) begin
        errors++;
        $display("FAIL reset_read off=%0d actual rdy=%b err=%b rd=%h cpu=%b required 1 0 0 0",
                 4 * k, rdy, er, rd, cpu_int);
      end
    end
  endtask

  task automatic test_edge_w1c();
    logic [31:0] rd;
    apb_write(BASE + 32'h8, 32'hFF, 4'hF);
    apb_write(BASE + 32'h4, 32'h05, 4'hF);
    irq_src = 8'h04;
    tick();
    checks++;
    if (cpu_int !== 1'b0) begin
      errors++; $display("FAIL edge_latency1 actual=%b required=0", cpu_int);
    end
    irq_src = 8'h00;
    tick();
    checks++;
    if (cpu_int !== 1'b1) begin
      errors++; $display("FAIL edge_latency2 actual=%b required=1", cpu_int);
    end
    apb_read(BASE, rd);
    checks++;
    if (rd !== 32'h04 || rd !== exp_rdata) begin
      errors++; $display("FAIL edge_pending actual=%h required=%h", rd, 32'h04);
    end
    apb_write(BASE, 32'h04, 4'hF);
    checks++;
    if (cpu_int !== 1'b1) begin
      errors++; $display("FAIL w1c_cpu_hold actual=%b required=1", cpu_int);
    end
    tick();
    checks++;
    if (cpu_int !== 1'b0 || cpu_int !== m_cpu) begin
      errors++; $display("FAIL w1c_cpu_drop actual=%b required=0", cpu_int);
    end
    apb_read(BASE, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL w1c_pending actual=%h required=0", rd);
    end
  endtask

  task automatic test_claim();
    logic [31:0] rd;
    logic [31:0] want[3];
    want[0] = 32'h8000_0001;
    want[1] = 32'h8000_0003;
    want[2] = 32'h0000_0000;
    irq_src = 8'h0A;
    tick();
    irq_src = 8'h00;
    tick();
    apb_write(BASE + 32'h4, 32'h0A, 4'hF);
    for (int k = 0; k < 3; k++) begin
      apb_read(BASE + 32'hC, rd);
      checks++;
      if (rd !== want[k] || rd !== exp_rdata) begin
        errors++; $display("FAIL claim_%0d actual=%h required=%h", k, rd, want[k]);
      end
    end
    apb_read(BASE, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL claim_pending actual=%h required=0", rd);
    end
  endtask

  task automatic test_level();
    logic [31:0] rd;
    apb_write(BASE + 32'h8, 32'h00, 4'hF);
    apb_write(BASE + 32'h4, 32'h01, 4'hF);
    irq_src = 8'h01;
    tick();
    apb_write(BASE, 32'h01, 4'hF);
    apb_read(BASE, rd);
    checks++;
    if (rd !== 32'h01 || rd !== exp_rdata) begin
      errors++; $display("FAIL level_w1c actual=%h required=%h", rd, 32'h01);
    end
    irq_src = 8'h00;
    tick();
    apb_read(BASE, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL level_drop actual=%h required=0", rd);
    end
  endtask

  task automatic test_set_wins();
    logic rdy, er;
    logic [31:0] rd;
    apb_write(BASE + 32'h8, 32'hFF, 4'hF);
    irq_src = 8'h10;
    tick();
    irq_src = 8'h00;
    tick();
    apb_begin(1'b1, BASE, 32'h10, 4'hF);
    irq_src = 8'h10;
    apb_end(rdy, rd, er);
    irq_src = 8'h00;
    apb_read(BASE, rd);
    checks++;
    if (rd !== 32'h10 || rd !== exp_rdata) begin
      errors++; $display("FAIL set_wins actual=%h required=%h", rd, 32'h10);
    end
    apb_write(BASE, 32'h10, 4'hF);
    apb_read(BASE, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL set_wins_clear actual=%h required=0", rd);
    end
  endtask

  task automatic test_errors_nmi();
    logic rdy, er;
    logic [31:0] rd;
    apb_begin(1'b0, BASE + 32'h10, 32'h0, 4'h0);
    apb_end(rdy, rd, er);
    checks++;
    if (rdy !== 1'b1 || er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL bad_addr actual rdy=%b err=%b rd=%h required 1 1 0", rdy, er, rd);
    end
    apb_write(BASE + 32'h4, 32'h0, 4'hF);
    apb_begin(1'b1, BASE + 32'h5, 32'hFF, 4'hF);
    apb_end(rdy, rd, er);
    checks++;
    if (er !== 1'b1 || er !== exp_err) begin
      errors++; $display("FAIL unaligned actual err=%b required=1", er);
    end
    apb_begin(1'b1, BASE + 32'h4, 32'hFFFF_FFFF, 4'b0010);
    apb_end(rdy, rd, er);
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("FAIL strobe_write_err actual=%b required=0", er);
    end
    apb_read(BASE + 32'h4, rd);
    checks++;
    if (rd !== 32'h0 || rd !== exp_rdata) begin
      errors++; $display("FAIL strobe_enable actual=%h required=0", rd);
    end
    nmi = 1'b1;
    tick();
    checks++;
    if (cpu_int !== 1'b1) begin
      errors++; $display("FAIL nmi_assert actual=%b required=1", cpu_int);
    end
    nmi = 1'b0;
    tick();
    checks++;
    if (cpu_int !== 1'b0) begin
      errors++; $display("FAIL nmi_release actual=%b required=0", cpu_int);
    end
  endtask

  task automatic test_random();
    logic rdy, er;
    logic [31:0] rd, addr;
    for (int n = 0; n < 400; n++) begin
      irq_src = NS'($urandom);
      nmi     = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) begin
        addr = BASE + 32'(4 * $urandom_range(0, 3));
        case ($urandom_range(0, 9))
          0: addr = addr + 32'h10;
          1: addr = addr + 32'h1;
          default: ;
        endcase
        apb_begin(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom));
        irq_src = NS'($urandom);
        apb_end(rdy, rd, er);
        checks++;
        if (rdy !== 1'b1 || rd !== exp_rdata || er !== exp_err) begin
          errors++;
          $display("FAIL rand_apb n=%0d addr=%h actual rdy=%b rd=%h err=%b required 1 %h %b",
                   n, addr, rdy, rd, er, exp_rdata, exp_err);
        end
      end else begin
        tick();
        checks++;
        if (bus.pready !== 1'b0 || bus.prdata !== 32'h0) begin
          errors++;
          $display("FAIL rand_idle n=%0d actual rdy=%b rd=%h required 0 0", n, bus.pready, bus.prdata);
        end
      end
      checks++;
      if (cpu_int !== m_cpu) begin
        errors++; $display("FAIL rand_cpu n=%0d actual=%b required=%b", n, cpu_int, m_cpu);
      end
    end
    irq_src = '0;
    nmi     = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic rdy, er;
    logic [31:0] rd;
    apb_write(BASE + 32'h4, 32'hFF, 4'hF);
    apb_begin(1'b0, BASE + 32'h4, 32'h0, 4'h0);
    apb_end(rdy, rd, er);
    checks++;
    if (rdy !== 1'b1 || rd !== 32'hFF) begin
      errors++; $display("FAIL pre_reset_read actual rdy=%b rd=%h required 1 000000ff", rdy, rd);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.pready !== 1'b0 || bus.prdata !== 32'h0 || cpu_int !== 1'b0) begin
      errors++;
      $display("FAIL async_reset actual rdy=%b rd=%h cpu=%b required 0 0 0", bus.pready, bus.prdata, cpu_int);
    end
    apply_reset();
    rst_n = 1'b1;
    apb_read(BASE + 32'h4, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++; $display("FAIL post_reset_enable actual=%h required=0", rd);
    end
  endtask

  initial begin
    test_reset();
    test_edge_w1c();
    test_claim();
    test_level();
    test_set_wins();
    test_errors_nmi();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
